// File: rtl/position_cache_read_sequencer_pkg.sv
// md_seq_pkg: shared types and defaults for the position-cache read sequencer.
//   DEF_NUM_CELLS        default number of cells / caches / PEs
//   DEF_PID_W            default particle-index width (cache depth = 2**PID_W)
//   DEF_CACHE_RD_LATENCY default cycles from rd_en to data at the mapping input
//   pid_t / cnt_t        particle index and particle count (one extra bit so a full cache fits)
//   seq_state_t          sequencer FSM states
package md_seq_pkg;

  localparam int DEF_NUM_CELLS        = 64;
  localparam int DEF_PID_W            = 4;
  localparam int DEF_CACHE_RD_LATENCY = 1;

  typedef logic [DEF_PID_W-1:0] pid_t;
  typedef logic [DEF_PID_W:0]   cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    HOME,
    NB,
    FLUSH
  } seq_state_t;

endpackage

// File: rtl/position_cache_read_sequencer_if.sv
// Bus between the sweep controller / PE array and the read sequencer.
//   start, cell_count, pe_ready     : into the sequencer
//   rd_en, rd_addr, home_phase      : broadcast cache read port
//   data_valid, data_is_home,
//   cell_valid                      : qualifiers aligned with cache read data
//   busy, done                      : sweep status
// slave is the sequencer side, master the controller/PE side.
interface position_cache_read_sequencer_if #(
  parameter int NUM_CELLS = 64,
  parameter int PID_W     = 4
);
  logic                           start;
  logic [NUM_CELLS*(PID_W+1)-1:0] cell_count;
  logic                           pe_ready;
  logic                           rd_en;
  logic [PID_W-1:0]               rd_addr;
  logic                           home_phase;
  logic                           data_valid;
  logic                           data_is_home;
  logic [NUM_CELLS-1:0]           cell_valid;
  logic                           busy;
  logic                           done;

  modport slave (
    input  start, cell_count, pe_ready,
    output rd_en, rd_addr, home_phase, data_valid, data_is_home, cell_valid, busy, done
  );

  modport master (
    output start, cell_count, pe_ready,
    input  rd_en, rd_addr, home_phase, data_valid, data_is_home, cell_valid, busy, done
  );
endinterface

// File: rtl/position_cache_read_sequencer_valid_delay_line.sv
// valid_delay_line: reset-to-zero shift register that delays a bundle of
// qualifier bits by DEPTH cycles so they line up with cache read data.
//   clk, rst : clock, asynchronous active-high reset
//   din      : WIDTH bits entering this cycle
//   dout     : din from DEPTH cycles ago (zero after reset)
module valid_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Clearing every stage on reset drops any reads still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/position_cache_read_sequencer.sv
// position_cache_read_sequencer: broadcast read-address sequencer for all
// position caches. For every home index hp it reads the home particle, then
// sweeps every neighbour index np, so all PEs see the same index together.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of position_cache_read_sequencer_if (see that file)
module position_cache_read_sequencer
  import md_seq_pkg::*;
#(
  parameter int NUM_CELLS        = DEF_NUM_CELLS,
  parameter int PID_W            = DEF_PID_W,
  parameter int CACHE_RD_LATENCY = DEF_CACHE_RD_LATENCY
) (
  input logic clk,
  input logic rst,
  position_cache_read_sequencer_if.slave bus
);

  localparam int CW = PID_W + 1;
  localparam int FW = (CACHE_RD_LATENCY < 2) ? 1 : $clog2(CACHE_RD_LATENCY + 1);

  seq_state_t           state, next_state;
  logic [CW-1:0]        count_reg [NUM_CELLS];
  logic [CW-1:0]        max_cnt;
  logic [PID_W-1:0]     hp, np;
  logic [FW-1:0]        flush_cnt;
  logic                 last_np, last_hp;
  logic                 rd_en, home_phase, done;
  logic [PID_W-1:0]     rd_addr;
  logic [NUM_CELLS-1:0] cmp_mask;
  logic [NUM_CELLS+1:0] delayed;

  // Largest cell population sets the sweep length for every cache.
  always_comb begin
    max_cnt = '0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (count_reg[c] > max_cnt) max_cnt = count_reg[c];
    end
  end

  // Only meaningful once max_cnt >= 1, which HOME/NB guarantee.
  assign last_np = ({1'b0, np} == max_cnt - CW'(1));
  assign last_hp = ({1'b0, hp} == max_cnt - CW'(1));

  // State, counters and captured counts. Counters only move on accepted
  // reads, so a stall holds the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hp        <= '0;
      np        <= '0;
      flush_cnt <= '0;
      for (int c = 0; c < NUM_CELLS; c++) count_reg[c] <= '0;
    end else begin
      state     <= next_state;
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            hp <= '0;
            for (int c = 0; c < NUM_CELLS; c++) count_reg[c] <= bus.cell_count[c*CW +: CW];
          end
        end
        HOME: begin
          if (bus.pe_ready) np <= '0;
        end
        NB: begin
          if (bus.pe_ready) begin
            if (last_np) begin
              if (!last_hp) hp <= hp + PID_W'(1);
            end else begin
              np <= np + PID_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and the read port. FLUSH waits out the cache latency so done
  // lands one cycle after the final data_valid.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    home_phase = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (bus.start) next_state = PREP;
      PREP: next_state = (max_cnt == '0) ? FLUSH : HOME;
      HOME: begin
        rd_addr = hp;
        if (bus.pe_ready) begin
          rd_en      = 1'b1;
          home_phase = 1'b1;
          next_state = NB;
        end
      end
      NB: begin
        rd_addr = np;
        rd_en   = bus.pe_ready;
        if (bus.pe_ready && last_np) next_state = last_hp ? FLUSH : HOME;
      end
      FLUSH: begin
        if (flush_cnt == FW'(CACHE_RD_LATENCY)) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Per-cell valid: this index exists in that cell. Gated by rd_en so idle
  // cycles carry an all-zero mask through the delay line.
  always_comb begin
    cmp_mask = '0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      cmp_mask[c] = rd_en && ({1'b0, rd_addr} < count_reg[c]);
    end
  end

  valid_delay_line #(
    .WIDTH (NUM_CELLS + 2),
    .DEPTH (CACHE_RD_LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en, home_phase, cmp_mask}),
    .dout (delayed)
  );

  assign bus.rd_en        = rd_en;
  assign bus.rd_addr      = rd_addr;
  assign bus.home_phase   = home_phase;
  assign bus.done         = done;
  assign bus.busy         = (state != IDLE);
  assign bus.data_valid   = delayed[NUM_CELLS+1];
  assign bus.data_is_home = delayed[NUM_CELLS];
  assign bus.cell_valid   = delayed[NUM_CELLS-1:0];

endmodule

// File: tb/tb_position_cache_read_sequencer.sv
// Self-checking bench for position_cache_read_sequencer. A sweep-level model
// (list of reads per sweep, issued on every ready cycle once PREP is over,
// data appearing LAT cycles later) is compared against the DUT every cycle,
// and directed sweeps pin the model with hand-computed numbers.
module tb_position_cache_read_sequencer;
  import md_seq_pkg::*;

  localparam int NC  = DEF_NUM_CELLS;
  localparam int PW  = DEF_PID_W;
  localparam int LAT = DEF_CACHE_RD_LATENCY;
  localparam int LOGN = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  position_cache_read_sequencer_if #(.NUM_CELLS(NC), .PID_W(PW)) bus ();

  position_cache_read_sequencer #(
    .NUM_CELLS(NC), .PID_W(PW), .CACHE_RD_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit home; int addr; } rd_t;
  typedef struct { int due; bit home; logic [NC-1:0] mask; } dv_t;

  rd_t readQ[$];
  dv_t dq[$];
  int  capCnt [NC];
  bit  active   = 0;
  int  startCyc = 0;
  int  doneCyc  = 0;

  always @(negedge clk) begin
    bit eRd, eHome, eDv, eDh, eBusy, eDone;
    int eAddr, mx;
    logic [NC-1:0] pMask, eMask;
    rd_t r;
    dv_t d;
    if (rst) begin
      active = 0;
      readQ.delete();
      dq.delete();
      checkOutput("rst_rd_en", bus.rd_en, 0);
      checkOutput("rst_rd_addr", bus.rd_addr, 0);
      checkOutput("rst_home_phase", bus.home_phase, 0);
      checkOutput("rst_data_valid", bus.data_valid, 0);
      checkOutput("rst_cell_valid", bus.cell_valid, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
    end else begin
      eRd = 0; eHome = 0; eAddr = 0; eDv = 0; eDh = 0; eMask = '0; pMask = '0;
      if (active && cyc >= startCyc + 2 && readQ.size() > 0 && bus.pe_ready) begin
        r = readQ.pop_front();
        eRd = 1; eHome = r.home; eAddr = r.addr;
        for (int c = 0; c < NC; c++) pMask[c] = (r.addr < capCnt[c]);
        dq.push_back('{cyc + LAT, r.home, pMask});
        if (readQ.size() == 0) doneCyc = cyc + LAT + 1;
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        d = dq.pop_front();
        eDv = 1; eDh = d.home; eMask = d.mask;
      end
      eBusy = active && cyc >= startCyc + 1 && cyc <= doneCyc;
      eDone = active && cyc == doneCyc;
      checkOutput("rd_en", bus.rd_en, eRd);
      checkOutput("home_phase", bus.home_phase, eRd && eHome);
      if (eRd) checkOutput("rd_addr", bus.rd_addr, eAddr);
      checkOutput("data_valid", bus.data_valid, eDv);
      checkOutput("data_is_home", bus.data_is_home, eDv && eDh);
      if (eDv) checkOutput("cell_valid", bus.cell_valid, eMask);
      checkOutput("busy", bus.busy, eBusy);
      checkOutput("done", bus.done, eDone);
      if (bus.start && !active) begin
        active = 1;
        startCyc = cyc;
        mx = 0;
        for (int c = 0; c < NC; c++) begin
          capCnt[c] = int'(bus.cell_count[c*(PW+1) +: PW+1]);
          if (capCnt[c] > mx) mx = capCnt[c];
        end
        for (int h = 0; h < mx; h++) begin
          readQ.push_back('{1'b1, h});
          for (int n = 0; n < mx; n++) readQ.push_back('{1'b0, n});
        end
        doneCyc = (mx == 0) ? cyc + 2 + LAT : 32'h3fff_ffff;
      end else if (active && cyc == doneCyc) begin
        active = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int cnt [NC];
  bit logRd [LOGN];
  int logAddr [LOGN];
  bit logDv [LOGN];
  logic [NC-1:0] logCv [LOGN];
  int nValid, lastAddr, lastRdRel, doneRel;

  task automatic loadCounts();
    for (int c = 0; c < NC; c++) bus.cell_count[c*(PW+1) +: PW+1] = (PW+1)'(cnt[c]);
  endtask

  task automatic setAll(input int v);
    for (int c = 0; c < NC; c++) cnt[c] = v;
    loadCounts();
  endtask

  // One sweep: start pulse, optional pe_ready stall window and optional extra
  // start pulse, all relative to the start cycle; logs DUT outputs per cycle.
  task automatic applyStimulus(input int stallOff, input int stallLen,
                               input int extraStartRel, input int budget);
    int s, rel;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pe_ready = 1'b1; s = cyc;
    for (int i = 0; i < LOGN; i++) begin
      logRd[i] = 0; logAddr[i] = 0; logDv[i] = 0; logCv[i] = '0;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0; nValid = 0; lastAddr = -1; lastRdRel = -1; doneRel = -1;
    while (!seen && (cyc - s) < budget) begin
      rel = cyc - s;
      bus.pe_ready = !(rel >= stallOff && rel < stallOff + stallLen);
      bus.start = (rel == extraStartRel);
      @(negedge clk);
      logRd[rel] = bus.rd_en; logAddr[rel] = int'(bus.rd_addr);
      logDv[rel] = bus.data_valid; logCv[rel] = bus.cell_valid;
      if (bus.data_valid) nValid++;
      if (bus.rd_en) begin lastAddr = int'(bus.rd_addr); lastRdRel = rel; end
      if (bus.done) begin seen = 1; doneRel = rel; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.pe_ready = 1'b1;
    if (!seen) checkOutput("sweep_timeout", 0, 1);
  endtask

  initial begin
    int s, stallDv;
    bus.start = 1'b0;
    bus.pe_ready = 1'b1;
    setAll(0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // all counts 3, always ready
    setAll(3);
    applyStimulus(1000, 0, -1, 100);
    checkOutput("t1_valid_count", nValid, 12);
    checkOutput("t1_last_rd_rel", lastRdRel, 13);
    checkOutput("t1_done_gap", doneRel - lastRdRel, 2);

    // sparse counts: cell 0 = 2, cell 5 = 4
    setAll(0); cnt[0] = 2; cnt[5] = 4; loadCounts();
    applyStimulus(1000, 0, -1, 100);
    checkOutput("t2_valid_count", nValid, 20);
    checkOutput("t2_mask_addr0", logCv[3], 64'h21);
    checkOutput("t2_mask_addr2", logCv[6], 64'h20);

    // all counts 0
    setAll(0);
    applyStimulus(1000, 0, -1, 50);
    checkOutput("t3_valid_count", nValid, 0);
    checkOutput("t3_no_reads", lastRdRel, -1);
    checkOutput("t3_done_rel", doneRel, 3);

    // counts 4, pe_ready low for 5 cycles starting at the np=2 read
    setAll(4);
    applyStimulus(5, 5, -1, 100);
    stallDv = 0;
    for (int i = 5; i < 10; i++) stallDv += int'(logDv[i]);
    checkOutput("t4_stall_rd_en", logRd[5], 0);
    checkOutput("t4_stall_addr", logAddr[5], 2);
    checkOutput("t4_stall_inflight", stallDv, 1);
    checkOutput("t4_resume_rd", logRd[10], 1);
    checkOutput("t4_resume_addr", logAddr[10], 2);
    checkOutput("t4_valid_count", nValid, 20);

    // full caches
    setAll(16);
    applyStimulus(1000, 0, -1, 300);
    checkOutput("t5_valid_count", nValid, 272);
    checkOutput("t5_last_addr", lastAddr, 15);

    // reset during NB, then a clean sweep with an ignored extra start
    setAll(4);
    @(posedge clk); #1;
    bus.start = 1'b1; s = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc - s < 6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_rd_en", bus.rd_en, 0);
    checkOutput("t6_rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    setAll(2);
    applyStimulus(1000, 0, 4, 100);
    checkOutput("t6_first_rd", logRd[2], 1);
    checkOutput("t6_first_addr", logAddr[2], 0);
    checkOutput("t6_valid_count", nValid, 6);
    checkOutput("t6_done_rel", doneRel, 9);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
